// File: rtl/hazard_ctrl.sv
// Stall/forward controller: shadows the E/M/W writers, decides D-stage stalls,
// D- and E-stage forward selects, and tracks the multiply/divide busy window.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_rs_used,
    input  logic       D_rt_used,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_wr,
    input  logic [1:0] D_tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic       E_flush,
    output logic [1:0] D_fwd_rs_sel,
    output logic [1:0] D_fwd_rt_sel,
    output logic [1:0] E_fwd_rs_sel,
    output logic [1:0] E_fwd_rt_sel,
    output logic       md_busy
);

    logic [4:0] e_wr, e_rs, e_rt, m_wr, w_wr;
    logic [1:0] e_tnew, m_tnew;
    logic       md_start_e, md_div_e;
    logic [3:0] cnt;

    function automatic logic hit(input logic [4:0] src, input logic [4:0] wr);
        return (wr != 5'd0) && (src == wr);
    endfunction

    function automatic logic [1:0] dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // The E writer is newest, so once it matches the M writer is irrelevant.
    function automatic logic data_hazard(
        input logic [4:0] src, input logic used, input logic [1:0] tuse,
        input logic [4:0] ewr, input logic [1:0] etn,
        input logic [4:0] mwr, input logic [1:0] mtn);
        if (!used)
            return 1'b0;
        if (hit(src, ewr))
            return etn > tuse;
        return hit(src, mwr) && (mtn > tuse);
    endfunction

    function automatic logic [1:0] d_sel(
        input logic [4:0] src,
        input logic [4:0] ewr, input logic [1:0] etn,
        input logic [4:0] mwr, input logic [1:0] mtn,
        input logic [4:0] wwr);
        if (hit(src, ewr))
            return (etn == 2'd0) ? 2'b01 : 2'b00;
        if (hit(src, mwr))
            return (mtn == 2'd0) ? 2'b10 : 2'b00;
        if (hit(src, wwr))
            return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [1:0] e_sel(
        input logic [4:0] src,
        input logic [4:0] mwr, input logic [1:0] mtn,
        input logic [4:0] wwr);
        if (hit(src, mwr) && (mtn == 2'd0))
            return 2'b01;
        if (hit(src, wwr))
            return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        md_busy      = md_start_e || (cnt != 4'd0);
        stall        = data_hazard(D_rs, D_rs_used, D_tuse_rs, e_wr, e_tnew, m_wr, m_tnew)
                    || data_hazard(D_rt, D_rt_used, D_tuse_rt, e_wr, e_tnew, m_wr, m_tnew)
                    || (D_md_use && md_busy);
        E_flush      = stall;
        D_fwd_rs_sel = d_sel(D_rs, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        D_fwd_rt_sel = d_sel(D_rt, e_wr, e_tnew, m_wr, m_tnew, w_wr);
        E_fwd_rs_sel = e_sel(e_rs, m_wr, m_tnew, w_wr);
        E_fwd_rt_sel = e_sel(e_rt, m_wr, m_tnew, w_wr);
    end

    // W's Tnew is always 0 after two decrements, so only its destination is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_wr       <= 5'd0;
            e_rs       <= 5'd0;
            e_rt       <= 5'd0;
            e_tnew     <= 2'd0;
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
            m_wr       <= 5'd0;
            m_tnew     <= 2'd0;
            w_wr       <= 5'd0;
            cnt        <= 4'd0;
        end else begin
            if (stall) begin
                e_wr       <= 5'd0;
                e_rs       <= 5'd0;
                e_rt       <= 5'd0;
                e_tnew     <= 2'd0;
                md_start_e <= 1'b0;
                md_div_e   <= 1'b0;
            end else begin
                e_wr       <= D_wr;
                e_rs       <= D_rs;
                e_rt       <= D_rt;
                e_tnew     <= D_tnew;
                md_start_e <= D_md_start;
                md_div_e   <= D_md_div;
            end
            m_wr   <= e_wr;
            m_tnew <= dec(e_tnew);
            w_wr   <= m_wr;
            if (md_start_e)
                cnt <= md_div_e ? 4'd10 : 4'd5;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cycle table, multi-cycle MD/reset sequences,
// and random traffic against an instruction-history reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_wr;
    logic       D_rs_used, D_rt_used, D_md_start, D_md_div, D_md_use;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       stall, E_flush, md_busy;
    logic [1:0] D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_rs_sel, E_fwd_rt_sel;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_used(D_rs_used), .D_rt_used(D_rt_used),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_wr(D_wr), .D_tnew(D_tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .stall(stall), .E_flush(E_flush),
        .D_fwd_rs_sel(D_fwd_rs_sel), .D_fwd_rt_sel(D_fwd_rt_sel),
        .E_fwd_rs_sel(E_fwd_rs_sel), .E_fwd_rt_sel(E_fwd_rt_sel),
        .md_busy(md_busy)
    );

    typedef struct {
        logic [4:0] rs, rt, wr;
        logic       rs_used, rt_used, md_start, md_div, md_use;
        logic [1:0] tuse_rs, tuse_rt, tnew;
    } din_t;

    typedef struct {
        din_t       d;
        logic       st;
        logic [1:0] drs, drt, ers, ert;
        logic       busy;
    } vec_t;

    // Reference model: the last three instructions that entered E, newest first.
    typedef struct {
        logic [4:0] wr, rs, rt;
        int         tnew;
        bit         md, dv;
    } ins_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];
    ins_t pipe[$];
    int   busy_end, cyc;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic din_t mk(input int rs, input int rsu, input int tr,
                                input int rt, input int rtu, input int tt,
                                input int wr, input int tn,
                                input int mds, input int mdd, input int mdu);
        din_t d;
        d.rs = 5'(rs);  d.rs_used = 1'(rsu); d.tuse_rs = 2'(tr);
        d.rt = 5'(rt);  d.rt_used = 1'(rtu); d.tuse_rt = 2'(tt);
        d.wr = 5'(wr);  d.tnew = 2'(tn);
        d.md_start = 1'(mds); d.md_div = 1'(mdd); d.md_use = 1'(mdu);
        return d;
    endfunction

    task automatic add(input din_t d, input int st, input int drs, input int drt,
                       input int ers, input int ert, input int busy);
        vec_t v;
        v.d = d; v.st = 1'(st); v.drs = 2'(drs); v.drt = 2'(drt);
        v.ers = 2'(ers); v.ert = 2'(ert); v.busy = 1'(busy);
        tbl.push_back(v);
    endtask

    task automatic drive(input din_t d);
        D_rs = d.rs; D_rt = d.rt; D_rs_used = d.rs_used; D_rt_used = d.rt_used;
        D_tuse_rs = d.tuse_rs; D_tuse_rt = d.tuse_rt; D_wr = d.wr; D_tnew = d.tnew;
        D_md_start = d.md_start; D_md_div = d.md_div; D_md_use = d.md_use;
    endtask

    function automatic int tnew_at(input ins_t i, input int k);
        return (i.tnew - k < 0) ? 0 : i.tnew - k;
    endfunction

    function automatic bit hits(input logic [4:0] x, input ins_t i);
        return (i.wr != 5'd0) && (i.wr == x);
    endfunction

    function automatic bit m_haz(input logic [4:0] x, input logic used, input logic [1:0] tuse);
        if (!used) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (hits(x, pipe[k])) return tnew_at(pipe[k], k) > int'(tuse);
        return 1'b0;
    endfunction

    function automatic int m_dsel(input logic [4:0] x);
        for (int k = 0; k < 3; k++)
            if (hits(x, pipe[k])) return (tnew_at(pipe[k], k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    function automatic int m_esel(input logic [4:0] x);
        if (hits(x, pipe[1]) && tnew_at(pipe[1], 1) == 0) return 1;
        if (hits(x, pipe[2])) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        ins_t b;
        b = '{wr: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0, md: 1'b0, dv: 1'b0};
        pipe.delete();
        repeat (3) pipe.push_back(b);
        busy_end = -1;
        cyc = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        din_t nop, lw, addu, beq, jal, jr, a1, sub, x0, rd0, mult, mflo, dv, mfhi, d;
        int   n;
        logic e_busy, e_st;
        ins_t ni;

        nop  = mk(0,0,0, 0,0,0, 0,0, 0,0,0);
        lw   = mk(2,1,1, 0,0,0, 1,2, 0,0,0);
        addu = mk(1,1,1, 3,1,1, 2,1, 0,0,0);
        beq  = mk(1,1,0, 0,1,0, 0,0, 0,0,0);
        jal  = mk(0,0,0, 0,0,0, 31,0, 0,0,0);
        jr   = mk(31,1,0, 0,0,0, 0,0, 0,0,0);
        a1   = mk(2,1,1, 3,1,1, 1,1, 0,0,0);
        sub  = mk(1,1,1, 5,1,1, 4,1, 0,0,0);
        x0   = mk(2,1,1, 0,0,0, 0,2, 0,0,0);
        rd0  = mk(0,1,0, 0,1,0, 0,0, 0,0,0);
        mult = mk(0,0,0, 0,0,0, 0,0, 1,0,1);
        mflo = mk(0,0,0, 0,0,0, 2,1, 0,0,1);
        dv   = mk(0,0,0, 0,0,0, 0,0, 1,1,1);
        mfhi = mk(0,0,0, 0,0,0, 3,1, 0,0,1);

        // load-use into ALU: one bubble, then W forward in E
        add(lw,   0,0,0,0,0,0);
        add(addu, 1,0,0,0,0,0);
        add(addu, 0,0,0,0,0,0);
        add(nop,  0,0,0,2,0,0);
        add(nop,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        // load into branch: two stalls, then W forward in D
        add(lw,   0,0,0,0,0,0);
        add(beq,  1,0,0,0,0,0);
        add(beq,  1,0,0,0,0,0);
        add(beq,  0,3,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        // jal then jr $31
        add(jal,  0,0,0,0,0,0);
        add(jr,   0,1,0,0,0,0);
        add(nop,  0,0,0,1,0,0);
        add(nop,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        // two writers of $1, reader picks the newest (M)
        add(a1,   0,0,0,0,0,0);
        add(a1,   0,0,0,0,0,0);
        add(sub,  0,0,0,0,0,0);
        add(nop,  0,0,0,1,0,0);
        add(nop,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        // writes to $0 never create hazards
        add(x0,   0,0,0,0,0,0);
        add(rd0,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);
        // mult then mflo: six busy cycles
        add(mult, 0,0,0,0,0,0);
        for (int i = 0; i < 6; i++) add(mflo, 1,0,0,0,0,1);
        add(mflo, 0,0,0,0,0,0);
        add(nop,  0,0,0,0,0,0);

        reset = 1'b0;
        drive(mk(1,1,0, 1,1,0, 1,2, 0,0,1));
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_flush", E_flush, 0);
        chk("rst_drs", D_fwd_rs_sel, 0);
        chk("rst_ers", E_fwd_rs_sel, 0);
        chk("rst_busy", md_busy, 0);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i].d);
            @(negedge clk);
            chk($sformatf("t%0d_stall", i), stall, tbl[i].st);
            chk($sformatf("t%0d_flush", i), E_flush, tbl[i].st);
            if (!tbl[i].st) begin
                chk($sformatf("t%0d_drs", i), D_fwd_rs_sel, tbl[i].drs);
                chk($sformatf("t%0d_drt", i), D_fwd_rt_sel, tbl[i].drt);
            end
            chk($sformatf("t%0d_ers", i), E_fwd_rs_sel, tbl[i].ers);
            chk($sformatf("t%0d_ert", i), E_fwd_rt_sel, tbl[i].ert);
            chk($sformatf("t%0d_busy", i), md_busy, tbl[i].busy);
        end

        // div then mfhi: stalled for 11 cycles
        @(posedge clk); #1; drive(dv);
        @(posedge clk); #1; drive(mfhi);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall) break;
            chk("div_busy", md_busy, 1);
            n++;
            @(posedge clk); #1;
        end
        chk("div_stall_cycles", n, 11);
        chk("div_release_busy", md_busy, 0);

        // asynchronous reset in the middle of a divide count
        @(posedge clk); #1; drive(dv);
        @(posedge clk); #1; drive(mfhi);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_stall", stall, 1);
        chk("pre_rst_busy", md_busy, 1);
        reset = 1'b0;
        #1;
        chk("async_rst_stall", stall, 0);
        chk("async_rst_flush", E_flush, 0);
        chk("async_rst_busy", md_busy, 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", md_busy, 0);
        chk("post_rst_stall", stall, 0);

        // random traffic against the model
        @(negedge clk); reset = 1'b0;
        drive(nop);
        #2; reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            d.rs = 5'($urandom_range(0, 3)); d.rt = 5'($urandom_range(0, 3));
            d.rs_used = 1'($urandom_range(0, 1)); d.rt_used = 1'($urandom_range(0, 1));
            d.tuse_rs = 2'($urandom_range(0, 2)); d.tuse_rt = 2'($urandom_range(0, 2));
            d.wr = 5'($urandom_range(0, 3)); d.tnew = 2'($urandom_range(0, 2));
            d.md_start = ($urandom_range(0, 15) == 0);
            d.md_div = 1'($urandom_range(0, 1));
            d.md_use = d.md_start | ($urandom_range(0, 7) == 0);
            drive(d);
            if (pipe[0].md) busy_end = cyc + (pipe[0].dv ? 10 : 5);
            e_busy = pipe[0].md || (cyc <= busy_end);
            e_st = m_haz(d.rs, d.rs_used, d.tuse_rs) || m_haz(d.rt, d.rt_used, d.tuse_rt)
                || (d.md_use && e_busy);
            @(negedge clk);
            chk("rnd_stall", stall, e_st);
            chk("rnd_flush", E_flush, e_st);
            chk("rnd_busy", md_busy, e_busy);
            chk("rnd_ers", E_fwd_rs_sel, m_esel(pipe[0].rs));
            chk("rnd_ert", E_fwd_rt_sel, m_esel(pipe[0].rt));
            if (!e_st) begin
                chk("rnd_drs", D_fwd_rs_sel, m_dsel(d.rs));
                chk("rnd_drt", D_fwd_rt_sel, m_dsel(d.rt));
            end
            if (e_st)
                ni = '{wr: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0, md: 1'b0, dv: 1'b0};
            else
                ni = '{wr: d.wr, rs: d.rs, rt: d.rt, tnew: int'(d.tnew), md: d.md_start, dv: d.md_div};
            void'(pipe.pop_back());
            pipe.push_front(ni);
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
